tqvp_hx2003_pulse_receiver: RTL and testbench

TinyQV user peripheral that captures a pulse train on one selected `ui_in` pin and stores it as 2-bit symbols. It is the receive-side counterpart of the pulse transmitter.
- Each completed level run is measured in prescaled ticks and classified as short or long against a per-level threshold.
- Symbols are packed into an 8-word (128-symbol) buffer, using the same encoding and packing as the transmitter program memory. A captured frame can be replayed or decoded directly.

---
 rtl/tqvp_hx2003_pulse_receiver_if.sv | 26 ++
 rtl/tqvp_hx2003_pulse_receiver.sv | 250 +++++++++++++++++++++++++
 tb/tb_tqvp_hx2003_pulse_receiver.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/tqvp_hx2003_pulse_receiver_if.sv
`default_nettype none
// ============================================================================
// Module  : tqvp_hx2003_pulse_receiver_if
// Brief   : TinyQV peripheral bus bundle for the pulse receiver.
// Revision: 1.0
// ============================================================================
interface tqvp_hx2003_pulse_receiver_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready, user_interrupt
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready, user_interrupt
  );
endinterface
`default_nettype wire

// File: rtl/tqvp_hx2003_pulse_receiver.sv
`default_nettype none
// ============================================================================
// Module  : tqvp_hx2003_pulse_receiver
// Brief   : Captures a pulse train on one ui_in pin as packed 2-bit symbols.
// Revision: 1.0
// ============================================================================
module tqvp_hx2003_pulse_receiver #(
  parameter int NUM_DATA_REG = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  tqvp_hx2003_pulse_receiver_if.slave bus
);
  // Symbol count is reported in an 8-bit field, so NUM_DATA_REG is 2..8.
  localparam int         WORD_W    = $clog2(NUM_DATA_REG);
  localparam logic [7:0] SYM_TOTAL = 8'(NUM_DATA_REG * 16);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        run_q, run_d;
  logic [3:0]  irq_stat_q, irq_stat_d;
  logic [3:0]  irq_en_q, irq_en_d;
  logic        invert_q, invert_d;
  logic        idle_lvl_q, idle_lvl_d;
  logic [2:0]  pin_sel_q, pin_sel_d;
  logic [7:0]  thr_lo_q, thr_lo_d;
  logic [7:0]  thr_hi_q, thr_hi_d;
  logic [7:0]  timeout_q, timeout_d;
  logic [3:0]  presc_q, presc_d;
  logic        level_q, level_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  duration_q, duration_d;
  logic [14:0] presc_cnt_q, presc_cnt_d;

  logic [31:0] sym_buf_q [NUM_DATA_REG];

  logic [3:0]  byte_en;
  logic        wr_reg0, wr_reg1;
  logic        pin_lvl, edge_det, tick_en, timeout_hit, is_long;
  logic [14:0] presc_mask;
  logic [7:0]  count_inc;
  logic [3:0]  irq_clr;
  logic        arm_go, start_go, sym_store, timeout_go;
  logic        ev_full, ev_half, ev_done;
  logic [WORD_W-1:0] buf_widx;
  logic [3:0]  buf_sidx;
  logic [1:0]  buf_wdata;
  logic [31:0] rdata;
  logic        unused_bits;

  always_comb begin
    byte_en = 4'b0000;
    case (bus.data_write_n)
      2'b00:   byte_en = 4'b0001;
      2'b01:   byte_en = 4'b0011;
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  assign wr_reg0 = (bus.address == 6'h00);
  assign wr_reg1 = (bus.address == 6'h04);

  // Level is taken after inversion, so every comparison below is polarity-free.
  assign pin_lvl     = ui_in[pin_sel_q] ^ invert_q;
  assign edge_det    = (pin_lvl != level_q);
  assign presc_mask  = (15'd1 << presc_q) - 15'd1;
  assign tick_en     = (presc_cnt_q == presc_mask);
  assign timeout_hit = (level_q == idle_lvl_q) && (duration_q >= timeout_q);
  assign is_long     = level_q ? (duration_q > thr_hi_q) : (duration_q > thr_lo_q);
  assign count_inc   = count_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (arm_go) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!run_q)        state_d = S_IDLE;
        else if (start_go) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (!run_q)                      state_d = S_IDLE;
        else if (ev_full || timeout_go)  state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    arm_go     = 1'b0;
    start_go   = 1'b0;
    sym_store  = 1'b0;
    timeout_go = 1'b0;
    ev_full    = 1'b0;
    ev_half    = 1'b0;
    ev_done    = 1'b0;
    case (state_q)
      S_IDLE:  arm_go   = run_q;
      S_ARMED: start_go = run_q && (pin_lvl != idle_lvl_q);
      S_CAPTURE: begin
        if (run_q) begin
          // An edge in the same cycle as a timeout stores its symbol instead.
          sym_store  = edge_det;
          timeout_go = !edge_det && timeout_hit;
          ev_full    = edge_det && (count_inc == SYM_TOTAL);
          ev_half    = edge_det && (count_q == 8'd63);
        end
      end
      default: ev_done = 1'b1;
    endcase
    uo_out = {5'b00000, level_q, (state_q == S_CAPTURE), 1'b0};
  end

  always_comb begin
    count_d     = count_q;
    duration_d  = duration_q;
    presc_cnt_d = presc_cnt_q;
    if (arm_go) begin
      count_d     = 8'd0;
      duration_d  = 8'd0;
      presc_cnt_d = 15'd0;
    end else if (start_go) begin
      duration_d  = 8'd0;
      presc_cnt_d = 15'd0;
    end else if (sym_store) begin
      count_d     = count_inc;
      duration_d  = 8'd0;
      presc_cnt_d = 15'd0;
    end else if ((state_q == S_CAPTURE) && run_q && !timeout_go) begin
      if (tick_en) begin
        presc_cnt_d = 15'd0;
        duration_d  = (duration_q == 8'hFF) ? 8'hFF : duration_q + 8'd1;
      end else begin
        presc_cnt_d = presc_cnt_q + 15'd1;
      end
    end
  end

  always_comb begin
    run_d      = run_q;
    irq_en_d   = irq_en_q;
    invert_d   = invert_q;
    idle_lvl_d = idle_lvl_q;
    pin_sel_d  = pin_sel_q;
    thr_lo_d   = thr_lo_q;
    thr_hi_d   = thr_hi_q;
    timeout_d  = timeout_q;
    presc_d    = presc_q;
    level_d    = pin_lvl;
    irq_clr    = 4'b0000;
    if (wr_reg0 && byte_en[0]) begin
      run_d   = bus.data_in[0];
      irq_clr = bus.data_in[4:1];
    end
    if (wr_reg0 && byte_en[1]) begin
      irq_en_d   = bus.data_in[11:8];
      invert_d   = bus.data_in[12];
      idle_lvl_d = bus.data_in[13];
    end
    if (wr_reg0 && byte_en[2]) pin_sel_d = bus.data_in[18:16];
    if (wr_reg1 && byte_en[0]) thr_lo_d  = bus.data_in[7:0];
    if (wr_reg1 && byte_en[1]) thr_hi_d  = bus.data_in[15:8];
    if (wr_reg1 && byte_en[2]) timeout_d = bus.data_in[23:16];
    if (wr_reg1 && byte_en[3]) presc_d   = bus.data_in[27:24];
    if (ev_done) run_d = 1'b0;
    // Hardware events are OR-ed in after the clear so they win a collision.
    irq_stat_d = (irq_stat_q & ~irq_clr) | {start_go, ev_half, ev_full, ev_done};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q       <= 1'b0;
      irq_stat_q  <= 4'd0;
      irq_en_q    <= 4'd0;
      invert_q    <= 1'b0;
      idle_lvl_q  <= 1'b0;
      pin_sel_q   <= 3'd0;
      thr_lo_q    <= 8'd0;
      thr_hi_q    <= 8'd0;
      timeout_q   <= 8'd0;
      presc_q     <= 4'd0;
      level_q     <= 1'b0;
      count_q     <= 8'd0;
      duration_q  <= 8'd0;
      presc_cnt_q <= 15'd0;
    end else begin
      run_q       <= run_d;
      irq_stat_q  <= irq_stat_d;
      irq_en_q    <= irq_en_d;
      invert_q    <= invert_d;
      idle_lvl_q  <= idle_lvl_d;
      pin_sel_q   <= pin_sel_d;
      thr_lo_q    <= thr_lo_d;
      thr_hi_q    <= thr_hi_d;
      timeout_q   <= timeout_d;
      presc_q     <= presc_d;
      level_q     <= level_d;
      count_q     <= count_d;
      duration_q  <= duration_d;
      presc_cnt_q <= presc_cnt_d;
    end
  end

  assign buf_widx  = count_q[4 +: WORD_W];
  assign buf_sidx  = count_q[3:0];
  assign buf_wdata = {level_q, is_long};

  // Buffer has no reset: its contents are only meaningful below symbol_count.
  always_ff @(posedge clk) begin
    if (sym_store) sym_buf_q[buf_widx][{buf_sidx, 1'b0} +: 2] <= buf_wdata;
  end

  always_comb begin
    rdata = 32'd0;
    if (bus.address[5]) begin
      rdata = sym_buf_q[bus.address[2 +: WORD_W]];
    end else begin
      case (bus.address)
        6'h00: rdata = {13'd0, pin_sel_q, 2'b00, idle_lvl_q, invert_q, irq_en_q,
                        3'b000, irq_stat_q, run_q};
        6'h04: rdata = {4'd0, presc_q, timeout_q, thr_hi_q, thr_lo_q};
        6'h08: rdata = {14'd0, state_q, duration_q, count_q};
        default: rdata = 32'd0;
      endcase
    end
  end

  assign bus.data_out       = rdata;
  assign bus.data_ready     = 1'b1;
  assign bus.user_interrupt = |(irq_stat_q & irq_en_q);

  assign unused_bits = &{1'b0, bus.data_read_n, bus.data_in[31:28]};
endmodule
`default_nettype wire

// File: tb/tb_tqvp_hx2003_pulse_receiver.sv
`default_nettype none
// ============================================================================
// Module  : tb_tqvp_hx2003_pulse_receiver
// Brief   : Directed bench with a symbol scoreboard for the pulse receiver.
// Revision: 1.0
// ============================================================================
module tb_tqvp_hx2003_pulse_receiver;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  tqvp_hx2003_pulse_receiver_if bus();

  tqvp_hx2003_pulse_receiver #(.NUM_DATA_REG(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [1:0]  exp_q[$];
  logic [7:0]  thr_lo = 8'd10;
  logic [7:0]  thr_hi = 8'd10;
  int          cur_pin = 0;
  logic        cur_inv = 1'b0;
  logic [31:0] v;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    bus.address = a;
    #1;
    d = bus.data_out;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] w);
    bus.address      = a;
    bus.data_in      = d;
    bus.data_write_n = w;
    tick(1);
    bus.data_write_n = 2'b11;
  endtask

  // Run of n clocks measures n-1 ticks at prescaler 0, saturating at 255.
  function automatic logic [1:0] model_sym(input logic lvl, input int n);
    int d;
    logic [7:0] thr;
    d   = (n - 1 > 255) ? 255 : n - 1;
    thr = lvl ? thr_hi : thr_lo;
    return {lvl, (d > int'(thr))};
  endfunction

  task automatic drive_run(input logic raw, input int n, input bit push);
    ui_in[cur_pin] = raw;
    if (push) exp_q.push_back(model_sym(raw ^ cur_inv, n));
    tick(1);
    bus.data_write_n = 2'b11;
    if (n > 1) tick(n - 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic [31:0] s;
    s = 32'hFFFF_FFFF;
    for (int k = 0; k < budget; k++) begin
      rd(6'h08, s);
      if (s[17:16] == 2'd0) break;
      tick(1);
    end
    chk(tag, {30'd0, s[17:16]}, 32'd0);
  endtask

  task automatic sb_check(input string tag);
    int k;
    logic [31:0] w;
    logic [1:0]  e;
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      rd(6'h20 + 6'(4 * (k / 16)), w);
      chk(tag, {30'd0, w[2 * (k % 16) +: 2]}, {30'd0, e});
      k++;
    end
  endtask

  initial begin
    rst              = 1'b1;
    ui_in            = 8'd0;
    bus.address      = 6'd0;
    bus.data_in      = 32'd0;
    bus.data_write_n = 2'b11;
    bus.data_read_n  = 2'b11;
    tick(3);
    rst = 1'b0;

    chk("rst_uo_out", {24'd0, uo_out}, 32'd0);
    chk("rst_irq", {31'd0, bus.user_interrupt}, 32'd0);
    chk("rst_ready", {31'd0, bus.data_ready}, 32'd1);
    rd(6'h00, v); chk("rst_reg0", v, 32'd0);
    rd(6'h04, v); chk("rst_reg1", v, 32'd0);
    rd(6'h08, v); chk("rst_status", v, 32'd0);

    // Basic capture, including a 16-bit write that must leave the upper half alone.
    wr(6'h04, 32'hAB32_0A0A, 2'b01);
    rd(6'h04, v); chk("wr16_reg1", v, 32'h0000_0A0A);
    wr(6'h04, 32'h0032_0A0A, 2'b10);
    wr(6'h00, 32'h0000_0F01, 2'b10);
    tick(1);
    rd(6'h08, v); chk("basic_armed", v, 32'h0001_0000);
    drive_run(1'b1, 5, 1'b1);
    drive_run(1'b0, 20, 1'b1);
    drive_run(1'b1, 20, 1'b1);
    ui_in[0] = 1'b0;
    wait_idle("basic_idle", 200);
    rd(6'h08, v); chk("basic_status", v, 32'h0000_3203);
    rd(6'h00, v); chk("basic_reg0", v, 32'h0000_0F12);
    chk("basic_irq", {31'd0, bus.user_interrupt}, 32'd1);
    sb_check("basic_sym");
    wr(6'h00, 32'hFFFF_FF1E, 2'b00);
    rd(6'h00, v); chk("w1c_reg0", v, 32'h0000_0F00);
    chk("w1c_irq", {31'd0, bus.user_interrupt}, 32'd0);
    rd(6'h0C, v); chk("unmapped", v, 32'd0);

    // Saturation and exact timeout position.
    wr(6'h00, 32'h0000_0F01, 2'b10);
    tick(1);
    ui_in[0] = 1'b1;
    exp_q.push_back(model_sym(1'b1, 400));
    tick(300);
    rd(6'h08, v); chk("sat_status", v, 32'h0002_FF00);
    tick(100);
    ui_in[0] = 1'b0;
    tick(50);
    rd(6'h08, v); chk("timeout_pre", v, 32'h0002_3101);
    tick(2);
    rd(6'h08, v); chk("timeout_done", v, 32'h0003_3201);
    tick(1);
    rd(6'h08, v); chk("timeout_idle", v, 32'h0000_3201);
    rd(6'h00, v); chk("timeout_reg0", v, 32'h0000_0F12);
    sb_check("sat_sym");

    // Buffer full: 130 alternating runs, half-way interrupt cleared mid-frame.
    wr(6'h00, 32'h0000_0F1F, 2'b10);
    tick(1);
    for (int j = 0; j < 130; j++) begin
      if (j == 80) begin
        rd(6'h00, v); chk("half_irq_set", {31'd0, v[3]}, 32'd1);
        bus.address      = 6'h00;
        bus.data_in      = 32'h0000_0009;
        bus.data_write_n = 2'b00;
      end
      drive_run((j % 2) == 0, ((j % 3) == 0) ? 12 : 3, j < 128);
    end
    wait_idle("full_idle", 20);
    rd(6'h08, v); chk("full_status", v, 32'h0000_0080);
    rd(6'h00, v); chk("full_reg0", v, 32'h0000_0F16);
    sb_check("full_sym");

    // Inverted input on pin 5: idle is raw low, a raw-high pulse is level 0.
    wr(6'h00, 32'h0005_3F1F, 2'b10);
    tick(1);
    ui_in[0] = 1'b1;
    tick(3);
    rd(6'h08, v); chk("inv_armed", v, 32'h0001_0000);
    cur_pin = 5;
    cur_inv = 1'b1;
    drive_run(1'b1, 12, 1'b1);
    chk("inv_uo_capture", {24'd0, uo_out}, 32'h0000_0002);
    ui_in[5] = 1'b0;
    wait_idle("inv_idle", 120);
    rd(6'h08, v); chk("inv_status", v, 32'h0000_3201);
    rd(6'h00, v); chk("inv_reg0", v, 32'h0005_3F12);
    chk("inv_uo_idle", {24'd0, uo_out}, 32'h0000_0004);
    sb_check("inv_sym");

    // Abort after three symbols, then re-arm.
    ui_in   = 8'd0;
    cur_pin = 0;
    cur_inv = 1'b0;
    wr(6'h00, 32'h0000_0F1F, 2'b10);
    tick(1);
    drive_run(1'b1, 4, 1'b1);
    drive_run(1'b0, 4, 1'b1);
    drive_run(1'b1, 4, 1'b1);
    ui_in[0] = 1'b0;
    tick(1);
    wr(6'h00, 32'h0000_0F00, 2'b10);
    tick(1);
    rd(6'h08, v); chk("abort_status", v & 32'h0003_00FF, 32'h0000_0003);
    rd(6'h00, v); chk("abort_reg0", v, 32'h0000_0F10);
    sb_check("abort_sym");
    wr(6'h00, 32'h0000_0F01, 2'b10);
    tick(1);
    rd(6'h08, v); chk("rearm_status", v, 32'h0001_0000);

    // Reset in the middle of a capture.
    ui_in[0] = 1'b1;
    tick(5);
    rd(6'h08, v); chk("pre_rst_state", {30'd0, v[17:16]}, 32'd2);
    rst   = 1'b1;
    ui_in = 8'd0;
    tick(1);
    rst = 1'b0;
    chk("rst2_uo_out", {24'd0, uo_out}, 32'd0);
    chk("rst2_irq", {31'd0, bus.user_interrupt}, 32'd0);
    chk("rst2_ready", {31'd0, bus.data_ready}, 32'd1);
    rd(6'h00, v); chk("rst2_reg0", v, 32'd0);
    rd(6'h04, v); chk("rst2_reg1", v, 32'd0);
    rd(6'h08, v); chk("rst2_status", v, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
